// File: rtl/flash_op_sched.sv
// flash_op_sched: sequences SPI flash page-program and sector-erase operations
// (write enable, command, address, data, status polling) over a byte engine.
module flash_op_sched #(
  parameter int CS_GAP  = 4,
  parameter int FIFO_AW = 4
) (
  input  logic        sclk,
  input  logic        rst,
  input  logic        op_req,
  input  logic        op_type,
  input  logic [23:0] op_addr,
  input  logic [7:0]  wr_data,
  input  logic        wr_vld,
  input  logic        wr_last,
  output logic        wr_rdy,
  output logic        busy,
  output logic        wr_end_flag,
  output logic        ce_end_flag,
  output logic        spi_start,
  output logic [7:0]  spi_tx,
  output logic        spi_cs_n,
  input  logic        spi_done,
  input  logic [7:0]  spi_rx
);
  localparam int CW = CS_GAP > 4 ? $clog2(CS_GAP) : 2;
  localparam logic [CW-1:0] GAP_END = CW'(CS_GAP - 1);

  typedef enum logic [3:0] {IDLE, WREN, GAP1, CMD, ADDR, DATA, GAP2, POLL, CHECK, DONE} state_t;
  state_t state, nxt;

  logic [CW-1:0]    cnt;
  logic [23:0]      addr;
  logic             op, wrap, issued, lst, done, push, pop, empty, gap_end, rx_unused;
  logic [8:0]       mem [2**FIFO_AW];
  logic [FIFO_AW:0] wp, rp;
  logic [8:0]       head;
  logic [7:0]       tx_byte;

  assign empty       = wp == rp;
  assign wr_rdy      = wp != {~rp[FIFO_AW], rp[FIFO_AW-1:0]};
  assign push        = wr_vld && wr_rdy;
  assign head        = mem[rp[FIFO_AW-1:0]];
  assign pop         = spi_start && state == DATA;
  assign done        = spi_done && issued;
  assign gap_end     = cnt == GAP_END;
  assign busy        = state != IDLE;
  assign wr_end_flag = state == DONE && !op;
  assign ce_end_flag = state == DONE && op;
  assign rx_unused   = ^spi_rx[7:1];
  // after a page-wrap poll, WREN first holds cs_n high for a full gap
  assign spi_cs_n    = !(state inside {CMD, ADDR, DATA, POLL, CHECK} || (state == WREN && !wrap));
  assign spi_start   = !issued && (state inside {CMD, ADDR, POLL, CHECK} ||
                       (state == WREN && !wrap) || (state == DATA && !empty));
  assign spi_tx      = spi_start ? tx_byte : 8'h00;

  always_comb begin
    tx_byte = state == WREN ? 8'h06 :
              state == CMD  ? (op ? 8'hD8 : 8'h02) :
              state == ADDR ? (cnt == '0 ? addr[23:16] : cnt == CW'(1) ? addr[15:8] : addr[7:0]) :
              state == DATA ? head[7:0] :
              state == POLL ? 8'h05 : 8'h00;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    nxt = op_req ? WREN : IDLE;
      WREN:    nxt = done ? GAP1 : WREN;
      GAP1:    nxt = gap_end ? CMD : GAP1;
      CMD:     nxt = done ? ADDR : CMD;
      ADDR:    nxt = done && cnt == CW'(2) ? (op ? GAP2 : DATA) : ADDR;
      DATA:    nxt = done && (lst || addr[7:0] == 8'h00) ? GAP2 : DATA;
      GAP2:    nxt = gap_end ? POLL : GAP2;
      POLL:    nxt = done ? CHECK : POLL;
      CHECK:   nxt = !done ? CHECK : spi_rx[0] ? GAP2 : wrap ? WREN : DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      addr   <= '0;
      op     <= 1'b0;
      wrap   <= 1'b0;
      issued <= 1'b0;
      lst    <= 1'b0;
      wp     <= '0;
      rp     <= '0;
    end else begin
      issued <= spi_start || (issued && !spi_done);
      if (push) wp <= wp + 1'b1;
      if (state == IDLE && op_req) begin
        op   <= op_type;
        addr <= op_addr;
        wrap <= 1'b0;
      end else if (pop) begin
        rp   <= rp + 1'b1;
        lst  <= head[8];
        addr <= addr + 24'd1;
      end
      // a non-final byte that completes a page forces a poll and restart
      if (state == DATA && done && !lst && addr[7:0] == 8'h00) wrap <= 1'b1;
      if (state == WREN && wrap && gap_end) wrap <= 1'b0;
      if (nxt != state) cnt <= '0;
      else if (state inside {GAP1, GAP2} || (state == WREN && wrap)) cnt <= gap_end ? '0 : cnt + CW'(1);
      else if (state == ADDR && done) cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge sclk)
    if (push) mem[wp[FIFO_AW-1:0]] <= {wr_last, wr_data};
endmodule

// File: tb/tb_flash_op_sched.sv
// tb_flash_op_sched: directed bench with a byte-engine responder, byte log and
// chip-select gap / end-pulse monitors.
module tb_flash_op_sched;
  typedef logic [7:0] bq_t[$];

  logic        sclk, rst, op_req, op_type, wr_vld, wr_last, spi_done;
  logic [23:0] op_addr;
  logic [7:0]  wr_data, spi_rx, spi_tx;
  logic        wr_rdy, busy, wr_end_flag, ce_end_flag, spi_start, spi_cs_n;

  int checks = 0, failures = 0;
  int wr_cnt, ce_cnt, falls, hi_run, min_gap, viol;
  bit hi_busy, inflight;
  logic prev_cs;
  bq_t log_q, status_q;

  flash_op_sched dut (
    .sclk(sclk), .rst(rst), .op_req(op_req), .op_type(op_type), .op_addr(op_addr),
    .wr_data(wr_data), .wr_vld(wr_vld), .wr_last(wr_last), .wr_rdy(wr_rdy),
    .busy(busy), .wr_end_flag(wr_end_flag), .ce_end_flag(ce_end_flag),
    .spi_start(spi_start), .spi_tx(spi_tx), .spi_cs_n(spi_cs_n),
    .spi_done(spi_done), .spi_rx(spi_rx)
  );

  initial sclk = 0;
  always #5 sclk = ~sclk;

  // byte engine: done two cycles after each start; status for the poll dummy byte
  initial begin
    logic [7:0] b, prev;
    prev = 8'h00;
    spi_done = 0;
    spi_rx = 8'h00;
    forever begin
      @(negedge sclk);
      if (spi_start) begin
        b = spi_tx;
        log_q.push_back(b);
        repeat (2) @(posedge sclk);
        #1 spi_done = 1;
        spi_rx = (prev == 8'h05 && b == 8'h00 && status_q.size() > 0) ? status_q.pop_front() : 8'h00;
        prev = b;
        @(posedge sclk);
        #1 spi_done = 0;
      end
    end
  end

  initial begin
    prev_cs = 1;
    inflight = 0;
    hi_busy = 0;
    hi_run = 0;
    viol = 0;
    forever begin
      @(negedge sclk);
      if (spi_done) inflight = 0;
      if (spi_start) begin
        if (inflight) viol++;
        inflight = 1;
      end
      if (wr_end_flag) wr_cnt++;
      if (ce_end_flag) ce_cnt++;
      if (!spi_cs_n) begin
        if (prev_cs) falls++;
        if (hi_run > 0 && hi_busy && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0;
        hi_busy = 1;
      end else begin
        hi_run++;
        if (!busy) hi_busy = 0;
      end
      prev_cs = spi_cs_n;
    end
  end

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear;
    log_q.delete();
    wr_cnt = 0;
    ce_cnt = 0;
    falls = 0;
    min_gap = 1000;
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    wr_data = d;
    wr_last = l;
    wr_vld = 1;
    tick;
    wr_vld = 0;
    wr_last = 0;
  endtask

  task automatic op(input logic t, input logic [23:0] a);
    op_type = t;
    op_addr = a;
    op_req = 1;
    tick;
    op_req = 0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 2000) begin
      tick;
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic wait_log(input int n);
    int k = 0;
    while (log_q.size() < n && k < 300) begin
      tick;
      k++;
    end
    chk("log_timeout", log_q.size() >= n, 1);
  endtask

  task automatic chk_log(input string tag, input bq_t e);
    chk({tag, "_len"}, log_q.size(), e.size());
    foreach (e[i]) if (i < log_q.size()) chk($sformatf("%s_b%0d", tag, i), log_q[i], e[i]);
  endtask

  initial begin
    rst = 1;
    op_req = 0; op_type = 0; op_addr = 0;
    wr_vld = 0; wr_last = 0; wr_data = 0;
    clear;
    repeat (3) tick;
    chk("rst_cs", spi_cs_n, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", spi_start, 0);
    chk("rst_tx", spi_tx, 0);
    chk("rst_rdy", wr_rdy, 1);
    chk("rst_flags", {wr_end_flag, ce_end_flag}, 0);
    rst = 0;
    tick;

    clear;
    status_q = '{8'h01, 8'h01, 8'h00};
    op(1, 24'h012000);
    wait_idle;
    chk_log("erase", '{8'h06, 8'hD8, 8'h01, 8'h20, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00});
    chk("erase_ce", ce_cnt, 1);
    chk("erase_wr", wr_cnt, 0);
    chk("erase_gap", min_gap, 4);
    chk("erase_cs_falls", falls, 5);

    clear;
    push(8'hAA, 0);
    push(8'hBB, 0);
    push(8'hCC, 1);
    op(0, 24'h000010);
    repeat (6) tick;
    op(1, 24'h0A0000);
    wait_idle;
    chk_log("prog", '{8'h06, 8'h02, 8'h00, 8'h00, 8'h10, 8'hAA, 8'hBB, 8'hCC, 8'h05, 8'h00});
    chk("prog_wr", wr_cnt, 1);
    chk("prog_ce", ce_cnt, 0);
    repeat (20) tick;
    chk("ignored_req_busy", busy, 0);

    clear;
    push(8'h11, 0);
    push(8'h22, 0);
    push(8'h33, 0);
    push(8'h44, 1);
    op(0, 24'h0000FE);
    wait_idle;
    chk_log("wrap", '{8'h06, 8'h02, 8'h00, 8'h00, 8'hFE, 8'h11, 8'h22, 8'h05, 8'h00,
                      8'h06, 8'h02, 8'h00, 8'h01, 8'h00, 8'h33, 8'h44, 8'h05, 8'h00});
    chk("wrap_wr", wr_cnt, 1);
    chk("wrap_gap", min_gap, 4);

    clear;
    push(8'h5A, 0);
    op(0, 24'h000020);
    wait_log(6);
    repeat (10) tick;
    chk("starve_cs", spi_cs_n, 0);
    chk("starve_nostart", log_q.size(), 6);
    chk("starve_busy", busy, 1);
    push(8'h6B, 1);
    wait_idle;
    chk_log("starve", '{8'h06, 8'h02, 8'h00, 8'h00, 8'h20, 8'h5A, 8'h6B, 8'h05, 8'h00});
    chk("starve_wr", wr_cnt, 1);

    clear;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk("fill_rdy15", wr_rdy, 1);
      push(8'h80 + 8'(i), i == 15);
    end
    chk("full_rdy", wr_rdy, 0);
    push(8'hEE, 1);
    chk("full_rdy_after_drop", wr_rdy, 0);
    op(0, 24'h000100);
    wait_idle;
    chk_log("full", '{8'h06, 8'h02, 8'h00, 8'h01, 8'h00,
                      8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h86, 8'h87,
                      8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F, 8'h05, 8'h00});
    chk("drain_rdy", wr_rdy, 1);
    clear;
    push(8'h77, 1);
    op(0, 24'h000200);
    wait_idle;
    chk_log("after_drop", '{8'h06, 8'h02, 8'h00, 8'h02, 8'h00, 8'h77, 8'h05, 8'h00});

    clear;
    op(1, 24'h056000);
    wait_log(3);
    #2 rst = 1;
    #1;
    chk("mid_rst_cs", spi_cs_n, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_start", spi_start, 0);
    chk("mid_rst_tx", spi_tx, 0);
    repeat (5) tick;
    rst = 0;
    clear;
    op(1, 24'h034000);
    chk("post_rst_accept", busy, 1);
    wait_idle;
    chk_log("post_rst", '{8'h06, 8'hD8, 8'h03, 8'h40, 8'h00, 8'h05, 8'h00});
    chk("post_rst_ce", ce_cnt, 1);
    chk("no_overlap", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
